// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting N_REQ requesters write access to one shared register.
// Each write takes IDLE -> GRANT -> DONE, with a registered one-hot grant and a one-cycle ack.
module reg_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       async_reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
    input  logic                       clr,
    output logic [N_REQ-1:0]           gnt,
    output logic                       ack,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(N_REQ)-1:0]   q_owner,
    output logic                       busy
);

    localparam int          IW = $clog2(N_REQ);
    localparam int unsigned NR = N_REQ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              ack_q, ack_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_q, last_d;

    logic [IW-1:0]     pick;
    logic [IW-1:0]     cand;
    logic              found;

    // Scan upward from the slot after the previous winner, wrapping at N_REQ-1.
    always_comb begin
        pick  = last_q;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand = IW'((32'(last_q) + k) % NR);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // last_q doubles as the winner of the transaction in flight: it only moves on IDLE->GRANT.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        data_d  = data_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                ack_d = 1'b0;
                if (clr) begin
                    data_d  = '0;
                    owner_d = '0;
                end else if (found) begin
                    last_d      = pick;
                    gnt_d[pick] = 1'b1;
                    state_d     = S_GRANT;
                end
            end
            S_GRANT: begin
                data_d  = wdata[int'(last_q)*WIDTH +: WIDTH];
                owner_d = last_q;
                ack_d   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                gnt_d   = '0;
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            owner_q <= '0;
            last_q  <= IW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign q       = data_q;
    assign q_owner = owner_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: timeline-based transaction model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reg_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           async_reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic           clr = 1'b0;
    logic [N-1:0]   gnt;
    logic           ack;
    logic [W-1:0]   q;
    logic [1:0]     q_owner;
    logic           busy;

    int errors = 0;
    int checks = 0;

    reg_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .req         (req),
        .wdata       (wdata),
        .clr         (clr),
        .gnt         (gnt),
        .ack         (ack),
        .q           (q),
        .q_owner     (q_owner),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an arbitration at edge index g makes gnt visible after g and g+1,
    // the write and ack happen at g+1, and the channel is free again after g+2.
    int edge_n  = 0;
    int g_start = -1;
    int m_win   = 0;
    int m_last  = N - 1;
    int m_q     = 0;
    int m_owner = 0;
    int winners[$];

    always @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            g_start = -1;
            m_last  = N - 1;
            m_q     = 0;
            m_owner = 0;
        end else begin
            edge_n++;
            if (g_start >= 0) begin
                if (edge_n - g_start == 1) begin
                    m_q     = int'(wdata[m_win*W +: W]);
                    m_owner = m_win;
                end else if (edge_n - g_start == 2) begin
                    g_start = -1;
                end
            end else if (clr) begin
                m_q     = 0;
                m_owner = 0;
            end else if (req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (req[(m_last + k) % N]) begin
                        m_win = (m_last + k) % N;
                        break;
                    end
                end
                m_last  = m_win;
                g_start = edge_n;
                winners.push_back(m_win);
            end
        end
    end

    initial begin : compare
        logic prev_ack;
        int   ph;
        prev_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!async_reset) begin
                ph = (g_start >= 0) ? edge_n - g_start : -1;
                check("gnt",     32'(gnt),     (ph == 0 || ph == 1) ? (32'd1 << m_win) : 32'd0);
                check("ack",     32'(ack),     32'(ph == 1));
                check("busy",    32'(busy),    32'(g_start >= 0));
                check("q",       32'(q),       32'(m_q));
                check("q_owner", 32'(q_owner), 32'(m_owner));
                check("gnt_onehot0", 32'($countones(gnt) <= 1), 32'd1);
                check("ack_not_twice", 32'(prev_ack && ack), 32'd0);
                prev_ack = ack;
            end else begin
                prev_ack = 1'b0;
            end
        end
    end

    // Runs n cycles; with auto_drop, the granted requester drops req in its ack cycle.
    task automatic serve(input int n, input bit auto_drop);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (auto_drop && ack)
                req = req & ~gnt;
        end
    endtask

    task automatic check_winners(input string name, input int exp[$]);
        check({name, "_count"}, 32'(winners.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < winners.size(); i++)
            check(name, 32'(winners[i]), 32'(exp[i]));
        winners.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        clr = 1'b0;
        async_reset = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        @(negedge clk);
        async_reset = 1'b0;
        winners.delete();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        do_reset();

        // Single write from requester 0.
        wdata[0*W +: W] = 8'hA5;
        req = 4'b0001;
        @(posedge clk); #1;
        check("sw_gnt", 32'(gnt), 32'h1);
        @(negedge clk);
        @(posedge clk); #1;
        check("sw_q", 32'(q), 32'hA5);
        check("sw_ack", 32'(ack), 32'd1);
        check("sw_owner", 32'(q_owner), 32'd0);
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        check("sw_gnt_off", 32'(gnt), 32'd0);
        check("sw_ack_off", 32'(ack), 32'd0);
        serve(2, 1'b0);
        winners.delete();

        // Round-robin with all requesting, twice.
        do_reset();
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        serve(13, 1'b1);
        req = 4'b1111;
        serve(13, 1'b1);
        check_winners("rr_order", '{0, 1, 2, 3, 0, 1, 2, 3});
        check("rr_last_q", 32'(q), 32'h44);

        // Wrap: last winner is 3, req=1001 held across two arbitrations.
        req = 4'b1001;
        serve(6, 1'b0);
        req = '0;
        serve(2, 1'b0);
        check_winners("wrap_order", '{0, 3});

        // Clear beats a same-cycle request.
        wdata[2*W +: W] = 8'h3C;
        req = 4'b0100;
        serve(4, 1'b1);
        check("clr_pre_q", 32'(q), 32'h3C);
        clr = 1'b1;
        req = 4'b0010;
        @(posedge clk); #1;
        check("clr_q", 32'(q), 32'h00);
        check("clr_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        check("clr_then_gnt", 32'(gnt), 32'h2);
        serve(4, 1'b1);
        check_winners("clr_order", '{2, 1});

        // Winner drops req in GRANT; data sampled at the GRANT->DONE edge.
        wdata[3*W +: W] = 8'h5A;
        req = 4'b1000;
        @(posedge clk); #1;
        check("drop_gnt", 32'(gnt), 32'h8);
        @(negedge clk);
        req = '0;
        wdata[3*W +: W] = 8'hC3;
        @(posedge clk); #1;
        check("drop_q", 32'(q), 32'hC3);
        check("drop_ack", 32'(ack), 32'd1);
        check("drop_owner", 32'(q_owner), 32'd3);
        @(posedge clk); #1;
        check("drop_ack_off", 32'(ack), 32'd0);
        serve(2, 1'b0);

        // Asynchronous reset between edges while in GRANT.
        wdata[0*W +: W] = 8'hFF;
        req = 4'b0001;
        @(posedge clk); #1;
        check("mid_gnt", 32'(gnt), 32'h1);
        #2;
        async_reset = 1'b1;
        #1;
        check("mid_gnt_rst", 32'(gnt), 32'd0);
        check("mid_busy_rst", 32'(busy), 32'd0);
        check("mid_q_rst", 32'(q), 32'h00);
        check("mid_ack_rst", 32'(ack), 32'd0);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        async_reset = 1'b0;
        serve(3, 1'b0);
        check("mid_q_after", 32'(q), 32'h00);

        // After reset, requester 0 has first priority again.
        winners.delete();
        req = 4'b0011;
        serve(4, 1'b1);
        req = '0;
        serve(4, 1'b1);
        check_winners("post_rst_order", '{0, 1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
